id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between the ID and EXE stages of the 5-stage ARM-subset core.
- Captures decoded control, operands and register indices each cycle.
- Its src1/src2 outputs feed the forwarding unit; its WB_EN/Dest outputs feed the EXE/MEM register.
- Supports freeze (memory stall hold), flush (taken branch), and a valid bit for bubbles.

Parameters:
- DW, 32, data/PC width
- EXE_CMD_W, 4, ALU command width
- RESET_PC, 0, PC value loaded on reset and on flush

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hold all contents (SRAM stall)
- flush  in  1  branch taken in EXE; insert bubble
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in  in  1 each  decoded control bits
- EXE_CMD_in  in  EXE_CMD_W  ALU command
- PC_in  in  DW  PC+4 of the ID instruction
- Val_Rn_in, Val_Rm_in  in  DW  register-file read data
- Shift_operand_in  in  12  shifter operand field
- Signed_imm_24_in  in  24  branch offset
- Dest_in, src1_in, src2_in  in  4 each  destination and source register indices
- SR_in  in  4  status flags {N,Z,C,V} at ID time
- valid_in  in  1  ID holds a real instruction
- the same names with suffix _out, same widths  out  registered copies
- valid_out  out  1  EXE holds a real instruction

Behaviour:
- All outputs are registered; latency is 1 cycle from _in to _out.
- Priority at each rising edge: rst > freeze > flush > load.
- rst:
  - All _out = 0, PC_out = RESET_PC, valid_out = 0.
  - A reset mid-operation discards the in-flight instruction.
- freeze = 1:
  - Every register holds its value, including valid_out.
  - flush is ignored that cycle. The branch stays in EXE, so flush reasserts after the freeze releases.
- flush = 1 (freeze = 0): bubble is loaded.
  - WB_EN, MEM_R_EN, MEM_W_EN, B, S = 0; valid_out = 0; EXE_CMD_out = 0.
  - Dest_out, src1_out, src2_out = 0.
  - Data fields are cleared to 0 and PC_out = RESET_PC.
- Load (neither asserted):
  - Every _out takes its _in value.
  - valid_out = valid_in.
  - If valid_in = 0, control bits (WB_EN, MEM_R_EN, MEM_W_EN, B, S) are forced to 0. A hazard bubble from ID therefore never writes, branches or sets flags.
- Invariant: valid_out = 0 implies WB_EN_out = MEM_R_EN_out = MEM_W_EN_out = B_out = S_out = 0. This keeps the downstream forwarding and hazard logic blind to bubbles.
- No width conversion; all fields pass through bit-exact.
- Back-to-back flush, or flush for multiple cycles, yields consecutive bubbles.
- freeze and flush both high: freeze wins, contents unchanged.

Decomposition:
- Shared package holds:
  - EXE_CMD encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR).
  - Status-bit index constants (N=3, Z=2, C=1, V=0).
  - RESET_PC default.
- One natural sub-module: pipe_field_reg, a generic DW-wide register with rst/hold/clear/load.
  - Instantiated per field group: control, data, indices.
  - Clear value is a parameter.

Test Plan:
- Reset: rst = 1 for 2 cycles with all inputs = 1 → all _out = 0, PC_out = RESET_PC, valid_out = 0.
- Normal load: valid_in = 1, WB_EN_in = 1, EXE_CMD_in = 4'b0010, Val_Rn_in = 32'h1234_5678, src1_in = 3, Dest_in = 5 → next cycle, identical values on _out and valid_out = 1.
- Freeze: load the instruction above, then freeze = 1 for 3 cycles while the inputs change to Val_Rn_in = 32'hDEAD_BEEF → _out stays 32'h1234_5678 all 3 cycles. Release freeze → new value appears 1 cycle later.
- Flush: B_in = 1, MEM_W_EN_in = 1, valid_in = 1 with flush = 1 → next cycle B_out = MEM_W_EN_out = WB_EN_out = 0, valid_out = 0, src1_out = src2_out = Dest_out = 0.
- Freeze + flush together: both = 1 with previously loaded WB_EN_out = 1 → WB_EN_out remains 1, valid_out remains 1.
- Bubble from ID: valid_in = 0, WB_EN_in = 1, S_in = 1, Dest_in = 7 → next cycle WB_EN_out = 0, S_out = 0, valid_out = 0, Dest_out = 7.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU command encodings,
// status-flag bit positions and the control-bit group carried through the stage.
package id_ex_stage_reg_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    // A bubble must never write, branch or touch flags downstream.
    function automatic ctrl_t mask_ctrl(ctrl_t c);
        ctrl_t r;
        r = c;
        if (!c.valid) begin
            r.wb_en    = 1'b0;
            r.mem_r_en = 1'b0;
            r.mem_w_en = 1'b0;
            r.b        = 1'b0;
            r.s        = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_field.sv
// Generic pipeline field register: synchronous reset and clear load CLR_VAL,
// hold keeps the current value, otherwise d is captured.
module pipe_field_reg #(
    parameter int          W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // hold outranks clear so a stalled branch stays put until the stall ends
    always_comb begin
        q_d = d;
        if (hold) begin
            q_d = q_q;
        end else if (clear) begin
            q_d = CLR_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= CLR_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: one-cycle capture of decoded control, operands and
// register indices, with freeze (stall hold), flush (branch bubble) and valid.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int             DW        = 32,
    parameter int             EXE_CMD_W = 4,
    parameter logic [DW-1:0]  RESET_PC  = DW'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 WB_EN_in,
    input  logic                 MEM_R_EN_in,
    input  logic                 MEM_W_EN_in,
    input  logic                 B_in,
    input  logic                 S_in,
    input  logic                 imm_in,
    input  logic [EXE_CMD_W-1:0] EXE_CMD_in,
    input  logic [DW-1:0]        PC_in,
    input  logic [DW-1:0]        Val_Rn_in,
    input  logic [DW-1:0]        Val_Rm_in,
    input  logic [11:0]          Shift_operand_in,
    input  logic [23:0]          Signed_imm_24_in,
    input  logic [3:0]           Dest_in,
    input  logic [3:0]           src1_in,
    input  logic [3:0]           src2_in,
    input  logic [3:0]           SR_in,
    input  logic                 valid_in,
    output logic                 WB_EN_out,
    output logic                 MEM_R_EN_out,
    output logic                 MEM_W_EN_out,
    output logic                 B_out,
    output logic                 S_out,
    output logic                 imm_out,
    output logic [EXE_CMD_W-1:0] EXE_CMD_out,
    output logic [DW-1:0]        PC_out,
    output logic [DW-1:0]        Val_Rn_out,
    output logic [DW-1:0]        Val_Rm_out,
    output logic [11:0]          Shift_operand_out,
    output logic [23:0]          Signed_imm_24_out,
    output logic [3:0]           Dest_out,
    output logic [3:0]           src1_out,
    output logic [3:0]           src2_out,
    output logic [3:0]           SR_out,
    output logic                 valid_out
);

    localparam int IDX_W  = EXE_CMD_W + 1 + 16;
    localparam int DATA_W = 2 * DW + 12 + 24;

    ctrl_t             ctrl_in;
    ctrl_t             ctrl_q;
    logic [IDX_W-1:0]  idx_in;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        ctrl_in = mask_ctrl('{valid:    valid_in,
                              wb_en:    WB_EN_in,
                              mem_r_en: MEM_R_EN_in,
                              mem_w_en: MEM_W_EN_in,
                              b:        B_in,
                              s:        S_in});
    end

    assign idx_in  = {EXE_CMD_in, imm_in, Dest_in, src1_in, src2_in, SR_in};
    assign data_in = {Val_Rn_in, Val_Rm_in, Shift_operand_in, Signed_imm_24_in};

    pipe_field_reg #(.W($bits(ctrl_t)), .CLR_VAL('0)) u_ctrl (
        .clk(clk), .rst(rst), .hold(freeze), .clear(flush),
        .d(ctrl_in), .q(ctrl_q)
    );

    pipe_field_reg #(.W(IDX_W), .CLR_VAL('0)) u_idx (
        .clk(clk), .rst(rst), .hold(freeze), .clear(flush),
        .d(idx_in), .q(idx_q)
    );

    pipe_field_reg #(.W(DATA_W), .CLR_VAL('0)) u_data (
        .clk(clk), .rst(rst), .hold(freeze), .clear(flush),
        .d(data_in), .q(data_q)
    );

    pipe_field_reg #(.W(DW), .CLR_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .hold(freeze), .clear(flush),
        .d(PC_in), .q(PC_out)
    );

    assign valid_out    = ctrl_q.valid;
    assign WB_EN_out    = ctrl_q.wb_en;
    assign MEM_R_EN_out = ctrl_q.mem_r_en;
    assign MEM_W_EN_out = ctrl_q.mem_w_en;
    assign B_out        = ctrl_q.b;
    assign S_out        = ctrl_q.s;

    assign {EXE_CMD_out, imm_out, Dest_out, src1_out, src2_out, SR_out} = idx_q;
    assign {Val_Rn_out, Val_Rm_out, Shift_operand_out, Signed_imm_24_out} = data_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed vector bench for id_ex_stage_reg: reset, load, freeze, flush,
// freeze+flush, ID bubble and full-width pass-through.
module tb_id_ex_stage_reg;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

    typedef struct packed {
        logic        valid;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic        imm;
        logic [3:0]  cmd;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } bus_t;

    typedef struct {
        logic rst;
        logic frz;
        logic fl;
        bus_t in;
        bus_t exp;
    } vec_t;

    logic clk;
    logic rst;
    logic freeze;
    logic flush;
    bus_t drv;
    bus_t got;

    int n_vec;
    int n_bad;

    vec_t vecs[$];

    bus_t ONES, RST_EXP, A, B, C, D, D_EXP, ONES_BUB;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    id_ex_stage_reg #(.DW(32), .EXE_CMD_W(4), .RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .WB_EN_in(drv.wb), .MEM_R_EN_in(drv.mr), .MEM_W_EN_in(drv.mw),
        .B_in(drv.b), .S_in(drv.s), .imm_in(drv.imm), .EXE_CMD_in(drv.cmd),
        .PC_in(drv.pc), .Val_Rn_in(drv.rn), .Val_Rm_in(drv.rm),
        .Shift_operand_in(drv.shift), .Signed_imm_24_in(drv.simm),
        .Dest_in(drv.dest), .src1_in(drv.src1), .src2_in(drv.src2),
        .SR_in(drv.sr), .valid_in(drv.valid),
        .WB_EN_out(got.wb), .MEM_R_EN_out(got.mr), .MEM_W_EN_out(got.mw),
        .B_out(got.b), .S_out(got.s), .imm_out(got.imm), .EXE_CMD_out(got.cmd),
        .PC_out(got.pc), .Val_Rn_out(got.rn), .Val_Rm_out(got.rm),
        .Shift_operand_out(got.shift), .Signed_imm_24_out(got.simm),
        .Dest_out(got.dest), .src1_out(got.src1), .src2_out(got.src2),
        .SR_out(got.sr), .valid_out(got.valid)
    );

    function automatic void add(logic r, logic fz, logic f, bus_t i, bus_t e);
        vec_t v;
        v.rst = r; v.frz = fz; v.fl = f; v.in = i; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, bus_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // drive away from the edge, sample 1 time unit after the capturing edge
    task automatic apply(logic r, logic fz, logic f, bus_t i);
        @(negedge clk);
        rst = r; freeze = fz; flush = f; drv = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; drv = '0;

        ONES    = '1;
        RST_EXP = '0;
        RST_EXP.pc = TB_RESET_PC;

        A = '0;
        A.valid = 1'b1; A.wb = 1'b1; A.s = 1'b1; A.imm = 1'b1;
        A.cmd = 4'b0010; A.pc = 32'h0000_0104;
        A.rn = 32'h1234_5678; A.rm = 32'h0BAD_F00D;
        A.shift = 12'hABC; A.simm = 24'h123456;
        A.dest = 4'd5; A.src1 = 4'd3; A.src2 = 4'd9; A.sr = 4'b1010;

        B = A;
        B.rn = 32'hDEAD_BEEF;

        C = '0;
        C.valid = 1'b1; C.b = 1'b1; C.mw = 1'b1; C.cmd = 4'b0111;
        C.pc = 32'h0000_0200; C.rn = 32'hCAFE_0001; C.rm = 32'h0000_00FF;
        C.shift = 12'h001; C.simm = 24'hFFFFFE;
        C.dest = 4'hE; C.src1 = 4'h1; C.src2 = 4'h2; C.sr = 4'b0101;

        D = '0;
        D.valid = 1'b0; D.wb = 1'b1; D.s = 1'b1; D.mr = 1'b1; D.mw = 1'b1; D.b = 1'b1;
        D.cmd = 4'b0100; D.pc = 32'h0000_0300; D.rn = 32'h5555_AAAA;
        D.rm = 32'h0F0F_0F0F; D.shift = 12'h3C3; D.simm = 24'h00ABCD;
        D.dest = 4'd7; D.src1 = 4'd6; D.src2 = 4'd8; D.sr = 4'b1111;

        D_EXP = D;
        D_EXP.wb = 1'b0; D_EXP.s = 1'b0; D_EXP.mr = 1'b0; D_EXP.mw = 1'b0; D_EXP.b = 1'b0;

        ONES_BUB = ONES;
        ONES_BUB.valid = 1'b0;
        ONES_BUB.wb = 1'b0; ONES_BUB.mr = 1'b0; ONES_BUB.mw = 1'b0;
        ONES_BUB.b = 1'b0; ONES_BUB.s = 1'b0;

        //   rst   frz   fl    inputs     expected
        add(1'b1, 1'b0, 1'b0, ONES,      RST_EXP);
        add(1'b1, 1'b0, 1'b0, ONES,      RST_EXP);
        add(1'b0, 1'b0, 1'b0, A,         A);
        add(1'b0, 1'b1, 1'b0, B,         A);
        add(1'b0, 1'b1, 1'b0, B,         A);
        add(1'b0, 1'b1, 1'b0, B,         A);
        add(1'b0, 1'b0, 1'b0, B,         B);
        add(1'b0, 1'b0, 1'b1, C,         RST_EXP);
        add(1'b0, 1'b0, 1'b1, C,         RST_EXP);
        add(1'b0, 1'b0, 1'b0, A,         A);
        add(1'b0, 1'b1, 1'b1, C,         A);
        add(1'b0, 1'b1, 1'b1, C,         A);
        add(1'b0, 1'b0, 1'b1, C,         RST_EXP);
        add(1'b0, 1'b0, 1'b0, C,         C);
        add(1'b0, 1'b0, 1'b0, D,         D_EXP);
        add(1'b0, 1'b0, 1'b0, A,         A);
        add(1'b1, 1'b1, 1'b1, ONES,      RST_EXP);
        add(1'b0, 1'b0, 1'b0, ONES,      ONES);
        add(1'b0, 1'b0, 1'b0, ONES_BUB,  ONES_BUB);
        add(1'b0, 1'b0, 1'b0, A,         A);
        add(1'b1, 1'b0, 1'b0, C,         RST_EXP);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].frz, vecs[i].fl, vecs[i].in);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // A frozen bubble must stay a bubble, then the stage reloads normally.
        apply(1'b0, 1'b0, 1'b0, D);
        check("bubble_load", D_EXP);
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b1, 1'b0, A);
            check($sformatf("bubble_frozen%0d", k), D_EXP);
        end
        apply(1'b0, 1'b0, 1'b0, A);
        check("bubble_release", A);

        // Branch held in EXE during a stall: flush takes effect only after release.
        apply(1'b0, 1'b1, 1'b1, C);
        check("stall_flush_hold", A);
        apply(1'b0, 1'b0, 1'b1, C);
        check("stall_flush_release", RST_EXP);
        apply(1'b0, 1'b0, 1'b0, B);
        check("after_flush_load", B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
